// File: rtl/chunked_add_sequencer.sv
// Multi-cycle add/subtract: one CHUNK-wide slice per cycle through a small ripple adder.
// Latency: out_valid rises NUMBITS/CHUNK cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result and flags held until out_valid && out_ready.

// Purely combinational ripple-carry adder used for one slice.
// Latency: 0 cycles.
// Backpressure: none.
module ripple_carry_adder #(
    parameter int NUMBITS = 8
) (
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               carryin,
    output logic [NUMBITS-1:0] result,
    output logic               carryout
);

    always_comb begin
        logic c;
        c = carryin;
        result = '0;
        for (int i = 0; i < NUMBITS; i++) begin
            result[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carryout = c;
    end

endmodule

module chunked_add_sequencer #(
    parameter int NUMBITS = 32,
    parameter int CHUNK   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] in_a,
    input  logic [NUMBITS-1:0] in_b,
    input  logic               in_carry,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero
);

    localparam int N    = NUMBITS / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [IDXW-1:0]    idx;
    logic               carry;
    logic [NUMBITS-1:0] a_reg;
    logic [NUMBITS-1:0] b_reg;

    logic [CHUNK-1:0]   slice_sum;
    logic               slice_co;
    logic [NUMBITS-1:0] next_result;
    logic               last_slice;

    ripple_carry_adder #(.NUMBITS(CHUNK)) u_slice_adder (
        .a        (a_reg[idx*CHUNK +: CHUNK]),
        .b        (b_reg[idx*CHUNK +: CHUNK]),
        .carryin  (carry),
        .result   (slice_sum),
        .carryout (slice_co)
    );

    assign in_ready   = (state == IDLE);
    assign last_slice = (idx == IDXW'(N - 1));

    // Full result as it will look after this cycle's slice is written back.
    always_comb begin
        next_result = result;
        next_result[idx*CHUNK +: CHUNK] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_sub ? ~in_b : in_b;
                        carry    <= in_sub ? 1'b1 : in_carry;
                        idx      <= '0;
                        result   <= '0;
                        carryout <= 1'b0;
                        overflow <= 1'b0;
                        zero     <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result <= next_result;
                    carry  <= slice_co;
                    idx    <= idx + IDXW'(1);
                    if (last_slice) begin
                        carryout  <= slice_co;
                        // Signed overflow: operands agree in sign, result does not.
                        overflow  <= (a_reg[NUMBITS-1] == b_reg[NUMBITS-1]) &&
                                     (slice_sum[CHUNK-1] != a_reg[NUMBITS-1]);
                        zero      <= ~|next_result;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Bench for chunked_add_sequencer (NUMBITS=32, CHUNK=8) with a queued reference model.
module tb_chunked_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_carry;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carryout;
    logic        overflow;
    logic        zero;

    chunked_add_sequencer #(.NUMBITS(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_carry  (in_carry),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ovf;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cyc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] full;
        bb    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        e.res = full[31:0];
        e.co  = full[32];
        e.ovf = (a[31] == bb[31]) && (e.res[31] != a[31]);
        e.z   = (e.res == 32'd0);
        return e;
    endfunction

    // Present an operand pair, wait for acceptance, then scramble the inputs.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub);
        int t = 0;
        sb.push_back(model(a, b, cin, sub));
        @(negedge clk);
        in_a = a; in_b = b; in_carry = cin; in_sub = sub; in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 0, 1);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_carry = 1'(($urandom)); in_sub = 1'(($urandom));
    endtask

    // Wait for out_valid, check latency and the popped expectation; out_ready must be 1.
    task automatic collect(input string tag);
        int   t = 0;
        exp_t e;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd4);
        e = sb.pop_front();
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_carryout"}, carryout, e.co);
        chk({tag, "_overflow"}, overflow, e.ovf);
        chk({tag, "_zero"}, zero, e.z);
        @(negedge clk);
        chk({tag, "_retired"}, out_valid, 0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_carry = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carryout, overflow, zero}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        chk("busy_in_ready", in_ready, 0);
        collect("t1_wrap");
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0); collect("t2_ovf");
        send(32'h00000005, 32'h00000007, 1'b0, 1'b1); collect("t3_sub_neg");
        send(32'h00000007, 32'h00000005, 1'b0, 1'b1); collect("t3_sub_pos");
        send(32'h000000FF, 32'h00000000, 1'b1, 1'b0); collect("t4_cin_slice");
        send(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0); collect("t4_ripple");
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0); collect("neg_ovf");
        send(32'h12345678, 32'h12345678, 1'b1, 1'b1); collect("sub_zero");

        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, 1'(($urandom)), 1'(($urandom)));
            collect("rand");
        end

        // Hold the result in DONE while a second operation is waiting.
        out_ready = 1'b0;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        e = sb.pop_front();
        begin
            int t = 0;
            while (!out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        chk("t5_latency", 64'(cyc - acc_cyc), 64'd4);
        in_a = 32'd100; in_b = 32'd23; in_carry = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_result", result, e.res);
            chk("t5_hold_flags", {carryout, overflow, zero}, {e.co, e.ovf, e.z});
            chk("t5_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_retired", out_valid, 0);
        chk("t5_idle_ready", in_ready, 1);
        chk("t5_result_kept", result, e.res);
        sb.push_back(model(32'd100, 32'd23, 1'b0, 1'b0));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        chk("t5_second_accepted", in_ready, 0);
        collect("t5_second");

        // Reset in the middle of RUN discards the operation.
        send(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_result", result, 0);
        chk("t6_rst_flags", {carryout, overflow, zero}, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_stale", out_valid, 0);
        end
        send(32'd3, 32'd4, 1'b0, 1'b0);
        collect("t6_after_rst");

        chk("sb_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
